// File: rtl/quotient_multiplier_unit.sv
// quotient_multiplier_unit: sequential shift-add multiplier that rebuilds a
// product from a multiplicand magnitude and a multiplier magnitude, consuming
// STEP multiplier bits per cycle, least-significant digit first.
module quotient_multiplier_unit #(
    parameter int unsigned A_W  = 23,
    parameter int unsigned B_W  = 13,
    parameter int unsigned STEP = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_W-1:0]     a_mag,
    input  logic [B_W-1:0]     b_mag,
    input  logic               sign_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_W+B_W-1:0] product,
    output logic               sign_out
);

    localparam int unsigned NSTEP = (B_W + STEP - 1) / STEP;
    localparam int unsigned BX_W  = NSTEP * STEP;
    localparam int unsigned ACC_W = A_W + BX_W;
    localparam int unsigned P_W   = A_W + B_W;
    localparam int unsigned CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [A_W-1:0]     a_lat;
    logic [BX_W-1:0]    b_lat;
    logic               sign_lat;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;

    logic [STEP-1:0]    digit_c;
    logic [ACC_W-1:0]   acc_sum_c;
    logic               last_c;

    // Only IDLE can take a new operand pair.
    assign in_ready = (state == IDLE);

    // Current digit's partial product, aligned and added to the accumulator.
    always_comb begin
        digit_c   = STEP'(b_lat >> (STEP * 32'(cnt)));
        acc_sum_c = acc + ((ACC_W'(a_lat) * ACC_W'(digit_c)) << (STEP * 32'(cnt)));
        last_c    = (cnt == CNT_W'(NSTEP - 1));
    end

    // Control FSM with registered datapath and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_lat     <= '0;
            b_lat     <= '0;
            sign_lat  <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            product   <= '0;
            sign_out  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_lat    <= a_mag;
                        b_lat    <= BX_W'(b_mag);
                        sign_lat <= sign_in;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_sum_c;
                    if (last_c) begin
                        cnt       <= '0;
                        product   <= acc_sum_c[P_W-1:0];
                        // Zero products never carry a negative sign.
                        sign_out  <= sign_lat & (acc_sum_c != '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quotient_multiplier_unit.sv
// Self-checking bench for quotient_multiplier_unit: fixed vectors, hand-written
// handshake/reset sequences and random back-to-back traffic against a
// plain-arithmetic product model.
module tb_quotient_multiplier_unit;

    localparam int unsigned A_W = 23;
    localparam int unsigned B_W = 13;
    localparam int unsigned P_W = A_W + B_W;
    localparam int          LAT = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] a_mag;
    logic [B_W-1:0] b_mag;
    logic           sign_in;
    logic           out_valid;
    logic           out_ready;
    logic [P_W-1:0] product;
    logic           sign_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    quotient_multiplier_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .sign_in   (sign_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .sign_out  (sign_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
        logic           s;
        logic [P_W-1:0] p;
        logic           sg;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Count edges until out_valid; in_ready must stay low meanwhile.
    task automatic wait_out(input string name, output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            chk({name, "_in_ready_busy"}, 64'(in_ready), 64'd0);
            step();
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(LAT));
    endtask

    // Present operands for one edge (caller ensures IDLE), then wait for result.
    task automatic op(input string name, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                      input logic s, output int lat);
        in_valid = 1'b1;
        a_mag    = a;
        b_mag    = b;
        sign_in  = s;
        step();
        in_valid = 1'b0;
        wait_out(name, lat);
    endtask

    function automatic logic [63:0] model_prod(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        return 64'(a) * 64'(b);
    endfunction

    initial begin
        int lat;
        int prev_acc;
        int acc_cyc;
        logic [A_W-1:0] ra;
        logic [B_W-1:0] rb;
        logic           rs;
        logic [63:0]    ep;

        vecs[0] = '{a: 23'd5,        b: 13'd3,      s: 1'b0, p: 36'd15,          sg: 1'b0};
        vecs[1] = '{a: 23'h7FFFFF,   b: 13'h1FFF,   s: 1'b1, p: 36'hFFF7FE001,   sg: 1'b1};
        vecs[2] = '{a: 23'd0,        b: 13'd7,      s: 1'b1, p: 36'd0,           sg: 1'b0};
        vecs[3] = '{a: 23'd1,        b: 13'd0,      s: 1'b1, p: 36'd0,           sg: 1'b0};
        vecs[4] = '{a: 23'h7FFFFF,   b: 13'd1,      s: 1'b0, p: 36'h7FFFFF,      sg: 1'b0};
        vecs[5] = '{a: 23'd1,        b: 13'h1FFF,   s: 1'b1, p: 36'h1FFF,        sg: 1'b1};
        vecs[6] = '{a: 23'h400000,   b: 13'h1000,   s: 1'b1, p: 36'h400000000,   sg: 1'b1};
        vecs[7] = '{a: 23'd16,       b: 13'd16,     s: 1'b0, p: 36'd256,         sg: 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_mag     = '0;
        b_mag     = '0;
        sign_in   = 1'b0;
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_product",   64'(product),   64'd0);
        chk("rst_sign_out",  64'(sign_out),  64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        rst = 1'b0;
        step();
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // Fixed vectors with out_ready held high.
        for (int i = 0; i < 8; i++) begin
            op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, lat);
            chk($sformatf("vec%0d_product", i), 64'(product), 64'(vecs[i].p));
            chk($sformatf("vec%0d_sign", i), 64'(sign_out), 64'(vecs[i].sg));
            step();
            chk($sformatf("vec%0d_valid_drop", i), 64'(out_valid), 64'd0);
            chk($sformatf("vec%0d_ready_back", i), 64'(in_ready), 64'd1);
        end

        // Backpressure: result held while blocked, new operands ignored.
        out_ready = 1'b0;
        op("bp", 23'd100, 13'd25, 1'b0, lat);
        in_valid = 1'b1;
        a_mag    = 23'd9;
        b_mag    = 13'd9;
        sign_in  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_product_hold", 64'(product), 64'd2500);
            chk("bp_valid_hold", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            step();
        end
        chk("bp_product_hold", 64'(product), 64'd2500);
        out_ready = 1'b1;
        step();
        chk("bp_valid_drop", 64'(out_valid), 64'd0);
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        wait_out("bp2", lat);
        chk("bp2_product", 64'(product), 64'd81);
        chk("bp2_sign", 64'(sign_out), 64'd1);
        step();

        // Reset during the second RUN cycle aborts without output.
        in_valid = 1'b1;
        a_mag    = 23'd1234;
        b_mag    = 13'd56;
        sign_in  = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_product",   64'(product),   64'd0);
        chk("abort_sign_out",  64'(sign_out),  64'd0);
        chk("abort_in_ready",  64'(in_ready),  64'd1);
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_output", 64'(out_valid), 64'd0);
            step();
        end
        op("post_abort", 23'd2, 13'd8, 1'b0, lat);
        chk("post_abort_product", 64'(product), 64'd16);
        chk("post_abort_sign", 64'(sign_out), 64'd0);
        step();

        // Random back-to-back traffic with in_valid and out_ready held high.
        prev_acc = -1;
        for (int i = 0; i < 20; i++) begin
            ra = A_W'($urandom);
            rb = B_W'($urandom);
            rs = 1'($urandom);
            if (i % 7 == 3) ra = '0;
            ep = model_prod(ra, rb);
            chk("rnd_in_ready", 64'(in_ready), 64'd1);
            in_valid = 1'b1;
            a_mag    = ra;
            b_mag    = rb;
            sign_in  = rs;
            step();
            acc_cyc = cyc;
            if (prev_acc >= 0) chk("rnd_spacing", 64'(acc_cyc - prev_acc), 64'd6);
            prev_acc = acc_cyc;
            a_mag   = A_W'($urandom);
            b_mag   = B_W'($urandom);
            sign_in = ~rs;
            wait_out($sformatf("rnd%0d", i), lat);
            chk($sformatf("rnd%0d_product", i), 64'(product), ep);
            chk($sformatf("rnd%0d_sign", i), 64'(sign_out), 64'(rs && (ep != 64'd0)));
            step();
        end
        in_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
